mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_pkg.sv | 9 +
 rtl/mem_wait_cnt.sv | 19 +
 rtl/mem_ctrl.sv | 85 ++++++++
 tb/tb_mem_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared defaults, FSM state type and a constant helper for the memory controller.
package mem_pkg;
  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [2:0] {IDLE, SETUP, WRITE, HOLD, RWAIT, RESP} state_e;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/mem_wait_cnt.sv
// mem_wait_cnt: loadable down-counter; done while the final cycle of a timed phase is in progress.
module mem_wait_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q;
  assign done_o = cnt_q == W'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - W'(1);
  end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: sequences single-word reads/writes onto a latch array, keeping the
// address stable for a full cycle on either side of every write-enable pulse.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WR_PULSE = 2,
  parameter int RD_WAIT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] arr_addr,
  output logic              arr_rw,
  output logic [DATA_W-1:0] arr_wdata,
  input  logic [DATA_W-1:0] arr_rdata,
  output logic              busy
);
  localparam int CW = $clog2(max2(WR_PULSE, RD_WAIT)) + 1;
  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              we_q;
  logic              arr_rw_q;
  logic              cnt_done;
  assign req_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign arr_addr  = addr_q;
  assign arr_wdata = wdata_q;
  assign arr_rw    = arr_rw_q;
  // Counter is loaded during SETUP so it holds the full width on the first WRITE/RWAIT cycle.
  mem_wait_cnt #(.W(CW)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (state_q == SETUP),
    .dec_i  (state_q == WRITE || state_q == RWAIT),
    .val_i  (we_q ? CW'(WR_PULSE) : CW'(RD_WAIT)),
    .done_o (cnt_done)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      arr_rw_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          state_q <= SETUP;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          we_q    <= req_we;
        end
        SETUP: begin
          state_q  <= we_q ? WRITE : RWAIT;
          arr_rw_q <= we_q;
        end
        WRITE: if (cnt_done) begin
          state_q  <= HOLD;
          arr_rw_q <= 1'b0;
        end
        HOLD: state_q <= IDLE;
        RWAIT: if (cnt_done) begin
          state_q <= RESP;
          rdata_q <= arr_rdata;
        end
        RESP: if (rsp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl against a behavioural 8x8 array and hand-computed values.
module tb_mem_ctrl;
  localparam int WR_PULSE = 2;
  localparam int RD_WAIT  = 1;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic [2:0] arr_addr;
  logic       arr_rw;
  logic [7:0] arr_wdata, arr_rdata;
  logic       busy;
  logic [7:0] mem [8];
  logic [2:0] prev_addr = '0;
  logic [2:0] acc_q [$];
  int         n_chk = 0, n_fail = 0, resp_cnt = 0, viol = 0;

  mem_ctrl #(.ADDR_W(3), .DATA_W(8), .WR_PULSE(WR_PULSE), .RD_WAIT(RD_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .arr_addr(arr_addr), .arr_rw(arr_rw), .arr_wdata(arr_wdata),
    .arr_rdata(arr_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  initial for (int i = 0; i < 8; i++) mem[i] = '0;
  assign arr_rdata = mem[arr_addr];
  always @(posedge clk) begin
    if (arr_rw) mem[arr_addr] <= arr_wdata;
    if (rsp_valid && rsp_ready) resp_cnt <= resp_cnt + 1;
    if (req_valid && req_ready && rst_n) acc_q.push_back(req_addr);
  end
  always @(negedge clk) begin
    if (arr_rw && arr_addr != prev_addr) viol <= viol + 1;
    prev_addr <= arr_addr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", req_ready, 1);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    int lat, rw;
    bit ok;
    wait_ready();
    req_valid = 1; req_we = 1; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 0; req_we = 0; req_addr = a + 3'd1; req_wdata = ~d;
    lat = 1; rw = 0; ok = 1;
    while (!req_ready && lat < 20) begin
      rw += int'(arr_rw);
      if (arr_addr != a || arr_wdata != d || !busy) ok = 0;
      @(negedge clk);
      lat++;
    end
    chk("wr_latency", lat, WR_PULSE + 3);
    chk("wr_pulse", rw, WR_PULSE);
    chk("wr_addr_data", ok, 1);
  endtask

  task automatic do_read(input logic [2:0] a, input logic [7:0] e, input int hold);
    int lat;
    bit stable;
    wait_ready();
    req_valid = 1; req_we = 0; req_addr = a;
    @(negedge clk);
    req_valid = 0; req_addr = ~a;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("rd_latency", lat, RD_WAIT + 2);
    chk("rd_data", rsp_rdata, e);
    stable = 1;
    repeat (hold) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata != e || req_ready) stable = 0;
    end
    if (hold > 0) chk("rd_hold_stable", stable, 1);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("rd_done", {rsp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [2:0] list [4];
    int k, got, n;
    list[0] = 3'd3; list[1] = 3'd6; list[2] = 3'd1; list[3] = 3'd4;
    #2;
    chk("rst_outputs", {arr_rw, rsp_valid, busy, req_ready}, 4'b0001);
    chk("rst_data", {rsp_rdata, arr_wdata, 5'd0, arr_addr}, 24'h0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    chk("rst_release_ready", req_ready, 1);
    @(negedge clk);
    chk("first_cycle_ready", {req_ready, busy}, 2'b10);
    do_write(3'd0, 8'h03);
    do_write(3'd1, 8'h05);
    do_read(3'd1, 8'h05, 0);
    do_read(3'd0, 8'h03, 0);
    do_read(3'd1, 8'h05, 4);
    chk("resp_count_a", resp_cnt, 3);
    // abort a write during its second enable cycle
    wait_ready();
    req_valid = 1; req_we = 1; req_addr = 3'd2; req_wdata = 8'hAA;
    @(negedge clk);
    req_valid = 0; req_we = 0;
    repeat (2) @(negedge clk);
    chk("mid_write_rw", arr_rw, 1);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_ctrl", {arr_rw, rsp_valid, busy, req_ready}, 4'b0001);
    chk("mid_rst_data", {rsp_rdata, arr_wdata, 5'd0, arr_addr}, 24'h0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("mid_rst_ready", {req_ready, busy, rsp_valid}, 3'b100);
    chk("resp_count_b", resp_cnt, 3);
    do_read(3'd2, 8'hAA, 0);
    chk("resp_count_c", resp_cnt, 4);
    for (int i = 0; i < 8; i++) do_write(3'(i), 8'hFF - 8'(i));
    for (int i = 0; i < 8; i++) do_read(3'(i), 8'hFF - 8'(i), 0);
    chk("addr_change_while_rw", viol, 0);
    // back-to-back reads with req_valid held and the address churning while busy
    wait_ready();
    acc_q.delete();
    rsp_ready = 1; req_we = 0; req_valid = 1;
    k = 0; got = 0; n = 0;
    while (got < 4 && n < 100) begin
      if (rsp_valid) begin
        chk("b2b_data", rsp_rdata, 8'hFF - {5'd0, list[got]});
        got++;
      end
      if (req_ready && k < 4) begin
        req_addr = list[k];
        k++;
      end else if (req_ready) req_valid = 0;
      else req_addr = 3'($urandom);
      @(negedge clk);
      n++;
    end
    req_valid = 0; rsp_ready = 0;
    chk("b2b_done", got, 4);
    chk("b2b_accepts", acc_q.size(), 4);
    for (int i = 0; i < 4 && i < acc_q.size(); i++) chk("b2b_accept_addr", acc_q[i], list[i]);
    chk("resp_count_final", resp_cnt, 16);
    chk("addr_change_final", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
